// File: rtl/spk_pkg.sv
// Shared types and widths for the threshold scheduler.
package spk_pkg;

  localparam int unsigned THR_W = 32;
  localparam int unsigned CH_W  = 8;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_ARMED = 2'd2,
    ST_COPY  = 2'd3
  } state_e;

endpackage

// File: rtl/spk_thr_ctrl_if.sv
// Host configuration port and FIR-to-detector stream bundled as one interface.
interface spk_thr_ctrl_if;
  import spk_pkg::*;

  logic                    cfg_wr_en;
  logic [CH_W-1:0]         cfg_ch;
  logic signed [THR_W-1:0] cfg_thr;
  logic                    cfg_commit;
  logic                    cfg_enable;
  logic                    cfg_ready;
  logic                    cfg_err;
  logic                    commit_done;

  logic                    valid_in;
  logic                    end_of_frame;
  logic [CH_W-1:0]         ch_No;
  logic signed [THR_W-1:0] v_in;

  logic                    valid_out;
  logic                    eof_out;
  logic [CH_W-1:0]         ch_out;
  logic signed [THR_W-1:0] v_out;
  logic signed [THR_W-1:0] threshold_out;
  logic                    thr_enable_out;
  logic [15:0]             frame_cnt;

  modport master (
    output cfg_wr_en, cfg_ch, cfg_thr, cfg_commit, cfg_enable,
    output valid_in, end_of_frame, ch_No, v_in,
    input  cfg_ready, cfg_err, commit_done,
    input  valid_out, eof_out, ch_out, v_out, threshold_out, thr_enable_out, frame_cnt
  );

  modport slave (
    input  cfg_wr_en, cfg_ch, cfg_thr, cfg_commit, cfg_enable,
    input  valid_in, end_of_frame, ch_No, v_in,
    output cfg_ready, cfg_err, commit_done,
    output valid_out, eof_out, ch_out, v_out, threshold_out, thr_enable_out, frame_cnt
  );

endinterface

// File: rtl/thr_bank_ram.sv
// One threshold bank: distributed RAM, one synchronous write port, two async read ports.
module thr_bank_ram
  import spk_pkg::*;
#(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [THR_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [THR_W-1:0]  rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [THR_W-1:0]  rdata_b
);

  logic [THR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/spk_thr_ctrl.sv
// Double-buffered per-channel threshold table that re-times the FIR stream for spkDet_A;
// bank swaps and enable changes only land on frame boundaries.
module spk_thr_ctrl
  import spk_pkg::*;
#(
  parameter int unsigned             NUM_CH      = 32,
  parameter logic signed [THR_W-1:0] THR_DEFAULT = -32'sd200
) (
  input logic           clk,
  input logic           rst,
  spk_thr_ctrl_if.slave bus
);

  localparam int unsigned      IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             active_sel_q, active_sel_d;
  logic             cfg_err_q, cfg_err_d;
  logic             commit_done_q, commit_done_d;
  logic             en_hold_q, thr_enable_q;
  logic [15:0]      frame_cnt_q;

  logic             valid_q, eof_q;
  logic [CH_W-1:0]  ch_q;
  logic [THR_W-1:0] v_q, thr_q, thr_d;

  logic             frame_end, cfg_ready, wr_ch_ok, smp_ch_ok;
  logic             init_we, shadow_we, we0, we1;
  logic [IDX_W-1:0] waddr;
  logic [THR_W-1:0] wdata;
  logic [THR_W-1:0] rd_smp0, rd_smp1, rd_cpy0, rd_cpy1, rd_smp, rd_cpy;

  assign frame_end = bus.valid_in & bus.end_of_frame;
  assign wr_ch_ok  = 32'(bus.cfg_ch) < NUM_CH;
  assign smp_ch_ok = 32'(bus.ch_No) < NUM_CH;

  // Bank active_sel_q feeds the stream; the other bank is the host-facing shadow.
  assign rd_smp = active_sel_q ? rd_smp1 : rd_smp0;
  assign rd_cpy = active_sel_q ? rd_cpy1 : rd_cpy0;
  assign we0    = init_we | (shadow_we & active_sel_q);
  assign we1    = init_we | (shadow_we & ~active_sel_q);

  thr_bank_ram #(
    .DEPTH  (NUM_CH),
    .ADDR_W (IDX_W)
  ) u_bank0 (
    .clk     (clk),
    .we      (we0),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (bus.ch_No[IDX_W-1:0]),
    .rdata_a (rd_smp0),
    .raddr_b (idx_q),
    .rdata_b (rd_cpy0)
  );

  thr_bank_ram #(
    .DEPTH  (NUM_CH),
    .ADDR_W (IDX_W)
  ) u_bank1 (
    .clk     (clk),
    .we      (we1),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (bus.ch_No[IDX_W-1:0]),
    .rdata_a (rd_smp1),
    .raddr_b (idx_q),
    .rdata_b (rd_cpy1)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    active_sel_d  = active_sel_q;
    commit_done_d = 1'b0;
    cfg_ready     = 1'b0;
    init_we       = 1'b0;
    shadow_we     = 1'b0;
    waddr         = bus.cfg_ch[IDX_W-1:0];
    wdata         = bus.cfg_thr;

    unique case (state_q)
      ST_INIT: begin
        init_we = 1'b1;
        waddr   = idx_q;
        wdata   = THR_DEFAULT;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
      end
      ST_IDLE, ST_ARMED: begin
        cfg_ready = 1'b1;
        shadow_we = bus.cfg_wr_en & wr_ch_ok;
        // A same-cycle write goes to the shadow, which is exactly the bank being promoted.
        if ((state_q == ST_ARMED || bus.cfg_commit) && frame_end) begin
          active_sel_d  = ~active_sel_q;
          commit_done_d = 1'b1;
          state_d       = ST_COPY;
          idx_d         = '0;
        end else if (bus.cfg_commit) begin
          state_d = ST_ARMED;
        end
      end
      ST_COPY: begin
        shadow_we = 1'b1;
        waddr     = idx_q;
        wdata     = rd_cpy;
        idx_d     = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
      end
      default: ;
    endcase

    cfg_err_d = cfg_err_q
              | ((bus.cfg_wr_en | bus.cfg_commit) & ~cfg_ready)
              | (bus.cfg_wr_en & cfg_ready & ~wr_ch_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_INIT;
      idx_q         <= '0;
      active_sel_q  <= 1'b0;
      cfg_err_q     <= 1'b0;
      commit_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      active_sel_q  <= active_sel_d;
      cfg_err_q     <= cfg_err_d;
      commit_done_q <= commit_done_d;
    end
  end

  always_comb begin
    thr_d = rd_smp;
    if (!smp_ch_ok) begin
      thr_d = '0;
    end else if (state_q == ST_INIT) begin
      thr_d = THR_DEFAULT;
    end
  end

  // The enable captured at the eof input is released one cycle later, so the eof sample
  // itself still carries the old enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      eof_q        <= 1'b0;
      ch_q         <= '0;
      v_q          <= '0;
      thr_q        <= '0;
      en_hold_q    <= 1'b0;
      thr_enable_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      valid_q <= bus.valid_in;
      eof_q   <= bus.end_of_frame;
      ch_q    <= bus.ch_No;
      v_q     <= bus.v_in;
      thr_q   <= thr_d;
      if (frame_end) begin
        en_hold_q   <= bus.cfg_enable;
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (valid_q && eof_q) begin
        thr_enable_q <= en_hold_q;
      end
    end
  end

  assign bus.cfg_ready      = cfg_ready;
  assign bus.cfg_err        = cfg_err_q;
  assign bus.commit_done    = commit_done_q;
  assign bus.valid_out      = valid_q;
  assign bus.eof_out        = eof_q;
  assign bus.ch_out         = ch_q;
  assign bus.v_out          = v_q;
  assign bus.threshold_out  = thr_q;
  assign bus.thr_enable_out = thr_enable_q;
  assign bus.frame_cnt      = frame_cnt_q;

endmodule

// File: tb/tb_spk_thr_ctrl.sv
// Scoreboard bench: a table-level model predicts every cycle's outputs, a monitor compares.
module tb_spk_thr_ctrl;
  import spk_pkg::*;

  localparam int NCH = 32;
  localparam int DEF = -200;

  typedef struct {
    bit          r;
    bit          wr;
    int          wch;
    int          wthr;
    bit          cm;
    bit          vin;
    bit          eof;
    int          ch;
    logic [31:0] v;
  } in_t;

  typedef struct {
    logic [31:0] ch;
    logic [31:0] v;
    bit          eof;
    int          thr;
    bit          en;
  } s_exp_t;

  typedef struct {
    bit rdy;
    bit err;
    bit done;
    bit en;
    int fcnt;
  } c_exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spk_thr_ctrl_if bus ();

  spk_thr_ctrl #(
    .NUM_CH      (NCH),
    .THR_DEFAULT (-32'sd200)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  s_exp_t sq[$];
  c_exp_t cq[$];
  int     total = 0;
  int     bad   = 0;
  bit     cur_en = 1'b0;

  // Reference model: logical active/shadow tables plus a busy countdown.
  int act [NCH];
  int shd [NCH];
  int busy;
  bit init_ph, pending, err, en_hold, en_out, prev_eof;
  int fcnt;

  function automatic void chk(string nm, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, a, e, $time);
    end
  endfunction

  function automatic in_t nop();
    in_t x;
    x = '{default: 0};
    return x;
  endfunction

  task automatic step(in_t x);
    c_exp_t c;
    s_exp_t s;
    bit     rdy, fe, done;
    @(negedge clk);
    rst              = x.r;
    bus.cfg_wr_en    = x.wr;
    bus.cfg_ch       = 8'(x.wch);
    bus.cfg_thr      = x.wthr;
    bus.cfg_commit   = x.cm;
    bus.cfg_enable   = cur_en;
    bus.valid_in     = x.vin;
    bus.end_of_frame = x.eof;
    bus.ch_No        = 8'(x.ch);
    bus.v_in         = x.v;
    c = '{rdy: 1'b0, err: 1'b0, done: 1'b0, en: 1'b0, fcnt: 0};
    if (x.r) begin
      for (int i = 0; i < NCH; i++) begin
        act[i] = DEF;
        shd[i] = DEF;
      end
      busy     = NCH;
      init_ph  = 1'b1;
      pending  = 1'b0;
      err      = 1'b0;
      en_hold  = 1'b0;
      en_out   = 1'b0;
      prev_eof = 1'b0;
      fcnt     = 0;
    end else begin
      rdy  = (busy == 0);
      fe   = x.vin && x.eof;
      done = 1'b0;
      if (prev_eof) en_out = en_hold;
      if (x.vin) begin
        s.ch  = 32'(x.ch);
        s.v   = x.v;
        s.eof = x.eof;
        s.thr = (x.ch >= NCH) ? 0 : (init_ph ? DEF : act[x.ch]);
        s.en  = en_out;
        sq.push_back(s);
      end
      if ((x.wr || x.cm) && !rdy) err = 1'b1;
      if (x.wr && rdy && x.wch >= NCH) err = 1'b1;
      if (x.wr && rdy && x.wch < NCH) shd[x.wch] = x.wthr;
      if (x.cm && rdy) pending = 1'b1;
      if (busy > 0) begin
        busy--;
        if (busy == 0) init_ph = 1'b0;
      end else if (pending && fe) begin
        act     = shd;  // after the copy, shadow mirrors the new active table
        pending = 1'b0;
        busy    = NCH;
        done    = 1'b1;
      end
      if (fe) begin
        en_hold = cur_en;
        fcnt    = (fcnt + 1) & 16'hFFFF;
      end
      prev_eof = fe;
      c = '{rdy: (busy == 0), err: err, done: done, en: en_out, fcnt: fcnt};
    end
    cq.push_back(c);
  endtask

  task automatic sample(int ch, bit eof);
    in_t x;
    x     = nop();
    x.vin = 1'b1;
    x.ch  = ch;
    x.eof = eof;
    x.v   = $urandom;
    step(x);
  endtask

  task automatic frame();
    for (int c = 0; c < NCH; c++) sample(c, c == NCH - 1);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(nop());
  endtask

  task automatic do_reset();
    in_t x;
    x   = nop();
    x.r = 1'b1;
    step(x);
    step(x);
  endtask

  task automatic commit();
    in_t x;
    x    = nop();
    x.cm = 1'b1;
    step(x);
  endtask

  task automatic write(int ch, int thr);
    in_t x;
    x      = nop();
    x.wr   = 1'b1;
    x.wch  = ch;
    x.wthr = thr;
    step(x);
  endtask

  // Monitor: control outputs every cycle, stream outputs whenever valid_out is high.
  initial begin
    c_exp_t c;
    s_exp_t s;
    forever begin
      @(posedge clk);
      #1;
      if (cq.size() > 0) begin
        c = cq.pop_front();
        chk("cfg_ready", 32'(bus.cfg_ready), 32'(c.rdy));
        chk("cfg_err", 32'(bus.cfg_err), 32'(c.err));
        chk("commit_done", 32'(bus.commit_done), 32'(c.done));
        chk("thr_enable_out", 32'(bus.thr_enable_out), 32'(c.en));
        chk("frame_cnt", 32'(bus.frame_cnt), 32'(c.fcnt));
      end
      if (bus.valid_out === 1'b1) begin
        if (sq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got valid_out=1, want 0 (t=%0t)", $time);
        end else begin
          s = sq.pop_front();
          chk("ch_out", 32'(bus.ch_out), s.ch);
          chk("v_out", bus.v_out, s.v);
          chk("eof_out", 32'(bus.eof_out), 32'(s.eof));
          chk("threshold_out", bus.threshold_out, 32'(s.thr));
          chk("sample_enable", 32'(bus.thr_enable_out), 32'(s.en));
        end
      end
    end
  end

  initial begin
    in_t x;
    int  cur_ch;

    // Init sweep with stream still flowing
    do_reset();
    for (int i = 0; i < NCH + 2; i++) sample(5, 1'b0);

    // Shadow write, commit, swap at frame end
    write(3, -500);
    commit();
    frame();
    frame();
    idle(4);

    // Write + commit + eof in one cycle
    for (int c = 0; c < NCH; c++) begin
      x     = nop();
      x.vin = 1'b1;
      x.ch  = c;
      x.v   = $urandom;
      x.eof = (c == NCH - 1);
      if (c == NCH - 1) begin
        x.wr   = 1'b1;
        x.wch  = 7;
        x.wthr = -900;
        x.cm   = 1'b1;
      end
      step(x);
    end
    frame();
    idle(NCH);

    // Out-of-range channel on both stream and write port
    x      = nop();
    x.vin  = 1'b1;
    x.ch   = 40;
    x.wr   = 1'b1;
    x.wch  = 40;
    x.wthr = 1234;
    step(x);
    sample(40, 1'b1);
    idle(2);

    // Write during COPY is dropped and flags an error
    do_reset();
    idle(NCH);
    commit();
    frame();
    write(9, 777);
    idle(NCH + 2);
    commit();
    frame();
    frame();

    // Enable raised mid-frame, then run the frame counter through its wrap
    for (int c = 0; c < NCH; c++) begin
      if (c == 10) cur_en = 1'b1;
      sample(c, c == NCH - 1);
    end
    frame();
    for (int i = 0; i < 65536; i++) sample(i % NCH, 1'b1);
    idle(2);

    // Randomised traffic, including resets mid-frame and mid-copy
    cur_ch = 0;
    for (int i = 0; i < 3000; i++) begin
      x = nop();
      x.r = ($urandom_range(0, 699) == 0);
      if ($urandom_range(0, 5) == 0) begin
        x.wr   = 1'b1;
        x.wch  = $urandom_range(0, 39);
        x.wthr = $urandom;
      end
      x.cm = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) cur_en = ~cur_en;
      if ($urandom_range(0, 3) != 0) begin
        x.vin = 1'b1;
        x.ch  = ($urandom_range(0, 31) == 0) ? $urandom_range(NCH, 255) : cur_ch;
        x.v   = $urandom;
        x.eof = (cur_ch == NCH - 1) || ($urandom_range(0, 15) == 0);
        cur_ch = x.eof ? 0 : cur_ch + 1;
      end
      step(x);
    end

    idle(3);
    @(posedge clk);
    #2;
    chk("stream_queue_drained", sq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
